// File: rtl/ram_pattern_tester_pkg.sv
// Shared types, widths and the address/seed test pattern for ram_pattern_tester.
package ram_pattern_tester_pkg;

  localparam int unsigned ERR_CNT_WIDTH = 16;
  // Working width of the pattern function; data and address widths up to this are supported.
  localparam int unsigned PAT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pattern word for an address: address zero-extended, XOR seed; caller truncates.
  function automatic logic [PAT_W-1:0] pattern_word(input logic [PAT_W-1:0] a,
                                                    input logic [PAT_W-1:0] s);
    return a ^ s;
  endfunction

endpackage

// File: rtl/ram_pattern_tester.sv
// Write a seeded address pattern over the whole RAM, read it back, count mismatches.
module ram_pattern_tester
  import ram_pattern_tester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     timeout,
  output logic                     ram_wr_en,
  output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic                     ram_rd_en,
  output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data,
  input  logic                     ram_rd_data_valid
);

  // Expected-address counter needs one extra bit: its MSB marks "all responses received".
  localparam int unsigned EXP_W   = ADDR_WIDTH + 1;
  localparam int unsigned DRAIN_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    seed_q, seed_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d, addr_inc;
  logic [EXP_W-1:0]         exp_q, exp_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  logic [ERR_CNT_WIDTH-1:0] err_d;
  logic [ADDR_WIDTH-1:0]    first_d;
  logic                     timeout_d, busy_d, done_d, pass_d;
  logic                     wr_en_d, rd_en_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_d, rd_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_d;
  logic [DATA_WIDTH-1:0]    exp_data;

  assign addr_inc = addr_q + ADDR_WIDTH'(1);
  assign exp_data = DATA_WIDTH'(pattern_word(PAT_W'(exp_q[ADDR_WIDTH-1:0]), PAT_W'(seed_q)));

  // State, counters and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      seed_q         <= '0;
      addr_q         <= '0;
      exp_q          <= '0;
      drain_q        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      ram_wr_en      <= 1'b0;
      ram_wr_addr    <= '0;
      ram_wr_data    <= '0;
      ram_rd_en      <= 1'b0;
      ram_rd_addr    <= '0;
    end else begin
      state_q        <= state_d;
      seed_q         <= seed_d;
      addr_q         <= addr_d;
      exp_q          <= exp_d;
      drain_q        <= drain_d;
      err_count      <= err_d;
      first_err_addr <= first_d;
      timeout        <= timeout_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      ram_wr_en      <= wr_en_d;
      ram_wr_addr    <= wr_addr_d;
      ram_wr_data    <= wr_data_d;
      ram_rd_en      <= rd_en_d;
      ram_rd_addr    <= rd_addr_d;
    end
  end

  // Next state, response checking and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    addr_d    = addr_q;
    exp_d     = exp_q;
    drain_d   = drain_q;
    err_d     = err_count;
    first_d   = first_err_addr;
    timeout_d = timeout;
    wr_en_d   = 1'b0;
    wr_addr_d = ram_wr_addr;
    wr_data_d = ram_wr_data;
    rd_en_d   = 1'b0;
    rd_addr_d = ram_rd_addr;

    // Read returns are in order, so the Nth valid belongs to address N; extras are dropped.
    if ((state_q == ST_READ || state_q == ST_DRAIN) && ram_rd_data_valid && !exp_q[ADDR_WIDTH]) begin
      exp_d = exp_q + EXP_W'(1);
      if (ram_rd_data != exp_data) begin
        if (err_count != '1) err_d = err_count + ERR_CNT_WIDTH'(1);
        if (err_count == '0) first_d = exp_q[ADDR_WIDTH-1:0];
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WRITE;
          seed_d    = seed;
          addr_d    = '0;
          exp_d     = '0;
          drain_d   = '0;
          err_d     = '0;
          first_d   = '0;
          timeout_d = 1'b0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = DATA_WIDTH'(pattern_word(PAT_W'(0), PAT_W'(seed)));
        end
      end
      ST_WRITE: begin
        if (addr_q == '1) begin
          state_d   = ST_READ;
          addr_d    = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end else begin
          addr_d    = addr_inc;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_inc;
          wr_data_d = DATA_WIDTH'(pattern_word(PAT_W'(addr_inc), PAT_W'(seed_q)));
        end
      end
      ST_READ: begin
        if (addr_q == '1) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          addr_d    = addr_inc;
          rd_en_d   = 1'b1;
          rd_addr_d = addr_inc;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (exp_d[ADDR_WIDTH]) begin
          state_d = ST_DONE;
        end else if (drain_q == DRAIN_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0) && !timeout_d;
  end

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Randomised and directed bench for ram_pattern_tester against a timeline model.
module tb_ram_pattern_tester;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 64;
  localparam int unsigned D  = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] seed;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          ram_wr_en, ram_rd_en, ram_rd_data_valid;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  ram_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM model: fixed-latency in-order read pipeline with optional corruption or silence.
  logic [DW-1:0] mem [D];
  logic          pv [8];
  logic [AW-1:0] pa [8];
  int            cfg_lat    = 1;
  bit            cfg_noresp = 1'b0;
  logic [D-1:0]  cfg_bad    = '0;

  initial for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pa[i] = '0; end

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    pv[0] <= ram_rd_en;
    pa[0] <= ram_rd_addr;
    for (int i = 1; i < 8; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  always @* begin
    ram_rd_data_valid = pv[cfg_lat-1] && !cfg_noresp;
    ram_rd_data       = mem[pa[cfg_lat-1]] ^ {7'b0, cfg_bad[pa[cfg_lat-1]]};
  end

  function automatic int lowest_bad(input logic [D-1:0] m);
    for (int i = 0; i < int'(D); i++) if (m[i]) return i;
    return 0;
  endfunction

  // Reference: a run is a timeline counted from the accepting edge (cycle 1 = first write).
  int          m_cyc     = 0;
  int          m_run_len = 0;
  int          m_err     = 0;
  int          m_first   = 0;
  bit          m_to      = 1'b0;
  logic [DW-1:0] m_seed  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0;
    end else if (start && !(m_cyc >= 1 && m_cyc <= m_run_len)) begin
      m_cyc     <= 1;
      m_seed    <= seed;
      m_run_len <= 2 * D + (cfg_noresp ? TO : cfg_lat);
      m_to      <= cfg_noresp;
      m_err     <= cfg_noresp ? 0 : $countones(cfg_bad);
      m_first   <= cfg_noresp ? 0 : lowest_bad(cfg_bad);
    end else if (m_cyc > 0) begin
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_first"}, first_err_addr, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_wr_en"}, ram_wr_en, 0);
    check({tag, "_wr_addr"}, ram_wr_addr, 0);
    check({tag, "_wr_data"}, ram_wr_data, 0);
    check({tag, "_rd_en"}, ram_rd_en, 0);
    check({tag, "_rd_addr"}, ram_rd_addr, 0);
  endtask

  // Per-cycle compare of every output against the timeline model.
  always @(negedge clk) begin : cmp
    bit in_w, in_r, fin;
    if (rst_n) begin
      if (m_cyc == 0) begin
        check_all_zero("idle");
      end else begin
        in_w = (m_cyc <= int'(D));
        in_r = (m_cyc > int'(D)) && (m_cyc <= 2 * int'(D));
        fin  = (m_cyc > m_run_len);
        check("busy", busy, !fin);
        check("wr_en", ram_wr_en, in_w);
        if (in_w) begin
          check("wr_addr", ram_wr_addr, m_cyc - 1);
          check("wr_data", ram_wr_data, ((m_cyc - 1) ^ int'(m_seed)) & 8'hFF);
        end
        check("rd_en", ram_rd_en, in_r);
        if (in_r) check("rd_addr", ram_rd_addr, m_cyc - int'(D) - 1);
        check("done", done, fin);
        check("timeout", timeout, fin && m_to);
        check("pass", pass, fin && m_err == 0 && !m_to);
        if (fin) begin
          check("err_count", err_count, m_err);
          check("first_err_addr", first_err_addr, m_first);
        end
      end
    end
  end

  task automatic do_start(input logic [DW-1:0] s);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_n);
    bit ok = 1'b0;
    busy_n = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_n++;
      @(negedge clk);
    end
    if (!ok) check("done_reached", 0, 1);
  endtask

  task automatic wait_wr(input logic [AW-1:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ram_wr_en && ram_wr_addr == a) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("wr_addr_reached", 0, 1);
  endtask

  task automatic wait_rd(input logic [AW-1:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ram_rd_en && ram_rd_addr == a) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("rd_addr_reached", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn;
    rst_n = 1'b0;
    start = 1'b0;
    seed  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, 1-cycle latency, seed 0xA5.
    do_start(8'hA5);
    check("lit_first_wr_data", ram_wr_data, 8'hA5);
    wait_done(2000, bn);
    check("lit_clean_busy_cycles", bn, 513);
    check("lit_clean_pass", pass, 1);
    check("lit_clean_err", err_count, 0);

    // Corrupted reads at 0x10 and 0x20.
    cfg_bad = '0;
    cfg_bad[8'h10] = 1'b1;
    cfg_bad[8'h20] = 1'b1;
    do_start(8'hA5);
    wait_done(2000, bn);
    check("lit_corrupt_err", err_count, 2);
    check("lit_corrupt_first", first_err_addr, 8'h10);
    check("lit_corrupt_pass", pass, 0);
    check("lit_corrupt_timeout", timeout, 0);
    cfg_bad = '0;

    // Silent RAM: drain must expire.
    cfg_noresp = 1'b1;
    do_start(8'h5A);
    wait_done(2000, bn);
    check("lit_to_busy_cycles", bn, 512 + 64);
    check("lit_to_timeout", timeout, 1);
    check("lit_to_pass", pass, 0);
    check("lit_to_err", err_count, 0);
    cfg_noresp = 1'b0;

    // Start during READ is ignored; start in DONE relatches seed.
    do_start(8'h5A);
    wait_rd(8'h30);
    start = 1'b1;
    seed  = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, bn);
    check("lit_ignored_pass", pass, 1);
    do_start(8'h3C);
    check("lit_new_seed_wr_data", ram_wr_data, 8'h3C);
    wait_done(2000, bn);
    check("lit_new_seed_pass", pass, 1);

    // Reset mid-WRITE at 0x40, then a clean run.
    do_start(8'hA5);
    wait_wr(8'h40);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_start(8'hA5);
    wait_done(2000, bn);
    check("lit_after_rst_busy_cycles", bn, 513);
    check("lit_after_rst_pass", pass, 1);

    // 5-cycle latency.
    cfg_lat = 5;
    do_start(8'hC3);
    wait_done(2000, bn);
    check("lit_lat5_drain", bn - 512, 5);
    check("lit_lat5_pass", pass, 1);

    // Randomised runs.
    for (int r = 0; r < 5; r++) begin
      int nb;
      cfg_lat = int'($urandom_range(1, 6));
      cfg_bad = '0;
      nb = int'($urandom_range(0, 3));
      for (int k = 0; k < nb; k++) cfg_bad[$urandom_range(0, D - 1)] = 1'b1;
      do_start(DW'($urandom));
      wait_done(2000, bn);
      check("rand_busy_cycles", bn, 512 + cfg_lat);
    end
    cfg_bad = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_pattern_tester.md
RAM_PATTERN_TESTER -- requirements
Module: ram_pattern_tester

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: RAM address width; depth = 2**ADDR_WIDTH; legal values are 1 or more.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of drain-phase cycles allowed for outstanding read data.
REQ-004 Port list SHALL be: clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle run request.
REQ-007 seed  in  DATA_WIDTH  pattern seed, sampled when start is accepted.
REQ-008 busy  out  1  high while a run is in progress.
REQ-009 done  out  1  high from run completion until the next accepted start.
REQ-010 pass  out  1  valid while done is high; 1 = no mismatches and no timeout.
REQ-011 err_count  out  16  count of mismatching read words; saturates.
REQ-012 first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
REQ-013 timeout  out  1  high when the drain phase expired.
REQ-014 ram_wr_en / ram_wr_addr / ram_wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  RAM write port.
REQ-015 ram_rd_en / ram_rd_addr  out  1 / ADDR_WIDTH  RAM read request.
REQ-016 ram_rd_data / ram_rd_data_valid  in  DATA_WIDTH / 1  RAM read return; latency is arbitrary but in-order.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE.
REQ-018 start SHALL be accepted in IDLE or DONE only; in WRITE, READ or DRAIN it SHALL be ignored.
REQ-019 Start acceptance SHALL take these actions:
- latch seed;
- clear err_count, first_err_addr, timeout, done and pass;
- move to WRITE on the next edge.
REQ-020 In WRITE, ram_wr_en SHALL be 1 for exactly 2**ADDR_WIDTH consecutive cycles, with ram_wr_addr running 0 to depth-1.
REQ-021 Write data SHALL be ram_wr_addr zero-extended or truncated to DATA_WIDTH, XOR latched seed.
REQ-022 After the last write cycle, READ SHALL follow with no gap.
REQ-023 In READ, ram_rd_en SHALL be 1 for 2**ADDR_WIDTH consecutive cycles, with ram_rd_addr running 0 to depth-1; the state then moves to DRAIN.
REQ-024 All RAM-facing outputs SHALL be registered; ram_wr_en and ram_rd_en SHALL be 0 outside WRITE and READ respectively.
REQ-025 In READ and DRAIN, each ram_rd_data_valid SHALL compare ram_rd_data against the pattern of an expected-address counter starting at 0, then increment that counter.
REQ-026 A valid in IDLE, WRITE or DONE, or a valid beyond depth responses, SHALL be ignored.
REQ-027 A mismatch SHALL increment err_count, saturating at 0xFFFF.
REQ-028 On the first mismatch of a run, first_err_addr SHALL capture the expected address; it SHALL remain 0 if there are no mismatches.
REQ-029 The DRAIN-to-DONE transition SHALL occur on the cycle after the depth-th valid is received, including when that valid arrives during READ.
REQ-030 In DRAIN, a cycle counter SHALL run; on reaching TIMEOUT_CYCLES with responses still missing, the block SHALL set timeout=1 and move to DONE.
REQ-031 In DONE, the outputs SHALL be busy=0, done=1, and pass = (err_count==0) AND NOT timeout.
REQ-032 busy SHALL be 1 exactly in WRITE, READ and DRAIN.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE and set every output to 0, including all RAM port outputs, counters and the latched seed.
REQ-034 A reset in any state SHALL abort the run; the first accepted start after release SHALL execute a complete, clean run.
REQ-035 Reset deassertion SHALL be synchronised externally; the block SHALL have no internal reset synchroniser.

Structure
REQ-036 Package ram_pattern_tester_pkg SHALL hold the state enum typedef, ERR_CNT_WIDTH=16, and the pattern function (addr, seed) -> data.
REQ-037 The block SHALL have no sub-module: one FSM plus address, expected-address, drain and error counters.

Verification
REQ-038 Bench RAM model with 1-cycle read latency; ADDR_WIDTH=8, seed=0xA5; start:
- expect 256 writes with data addr^0xA5, then 256 reads;
- expect done with pass=1, err_count=0.
REQ-039 Model corrupts bit0 of the address-0x10 and address-0x20 reads:
- expect err_count=2, first_err_addr=0x10, pass=0, timeout=0.
REQ-040 Model never asserts ram_rd_data_valid:
- expect DONE exactly TIMEOUT_CYCLES cycles after entering DRAIN;
- expect timeout=1, pass=0, err_count=0.
REQ-041 Pulse start again during READ:
- expect it ignored, with no phase restart or counter clear;
- a start in DONE with seed=0x3C then runs with the new pattern.
REQ-042 Assert rst_n low mid-WRITE at address 0x40:
- expect all outputs 0 immediately, with no further RAM enables;
- a following start yields a full pass run.
REQ-043 Model with 5-cycle latency:
- expect the DRAIN length to equal the latency, with pass=1.
